nspi_rx: RTL and testbench

NSPI_RX -- requirements
Module: nspi_rx

---
 rtl/nspi_pkg.sv | 13 +
 rtl/nspi_sync.sv | 33 +++
 rtl/nspi_rx.sv | 159 +++++++++++++++
 tb/tb_nspi_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nspi_pkg.sv
// Shared types and default geometry for the nspi serial link (receiver and transmitter).
package nspi_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RECEIVE = 1'b1
  } rx_state_t;

  localparam int unsigned NSPI_CHANNEL_NUMBER = 3;
  localparam int unsigned NSPI_SPI_SIZE       = 8;
  localparam bit          NSPI_MSB_FIRST      = 1'b1;

endpackage

// File: rtl/nspi_sync.sv
// Multi-bit flop-chain synchronizer; all bits share one depth so lanes stay aligned.
module nspi_sync #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = din;
    for (int i = 1; i < int'(DEPTH); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/nspi_rx.sv
// Multi-lane SPI-style receiver: oversamples spi_clk/spi_mosi in the clk domain,
// assembles one word per lane and hands it over through a valid/ready output register.
module nspi_rx
  import nspi_pkg::*;
#(
  parameter int unsigned CHANNEL_NUMBER = NSPI_CHANNEL_NUMBER,
  parameter int unsigned SPI_SIZE       = NSPI_SPI_SIZE,
  parameter bit          MSB_FIRST      = NSPI_MSB_FIRST,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      spi_clk,
  input  logic [CHANNEL_NUMBER-1:0] spi_mosi,
  output logic [SPI_SIZE-1:0]       data_out [CHANNEL_NUMBER-1:0],
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic                      overrun,
  output logic                      rx_busy
);

  localparam int unsigned CNT_W  = $clog2(SPI_SIZE + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SYNC_W = CHANNEL_NUMBER + 1;

  logic [SYNC_W-1:0]         sync_out;
  logic                      sclk_s;
  logic [CHANNEL_NUMBER-1:0] mosi_s;
  logic                      sclk_prev_q;
  logic                      edge_c;
  logic                      complete_c;
  logic [SPI_SIZE-1:0]       keep_c;

  rx_state_t           state_q,   state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]    tmo_q,     tmo_d;
  logic                valid_q,   valid_d;
  logic                overrun_q, overrun_d;
  logic [SPI_SIZE-1:0] shift_q    [CHANNEL_NUMBER-1:0];
  logic [SPI_SIZE-1:0] shift_d    [CHANNEL_NUMBER-1:0];
  logic [SPI_SIZE-1:0] shift_in_c [CHANNEL_NUMBER-1:0];
  logic [SPI_SIZE-1:0] data_q     [CHANNEL_NUMBER-1:0];
  logic [SPI_SIZE-1:0] data_d     [CHANNEL_NUMBER-1:0];

  // Clock and data ride the same chain so a detected edge sees its own data bit.
  nspi_sync #(
    .WIDTH (SYNC_W),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({spi_clk, spi_mosi}),
    .dout  (sync_out)
  );

  assign sclk_s = sync_out[SYNC_W-1];
  assign mosi_s = sync_out[CHANNEL_NUMBER-1:0];
  assign edge_c = sclk_s & ~sclk_prev_q;

  // In IDLE the old shift contents are masked off so the first bit starts a clean word.
  assign keep_c = (state_q == RECEIVE) ? '1 : '0;

  always_comb begin
    shift_in_c = shift_q;
    for (int i = 0; i < int'(CHANNEL_NUMBER); i++) begin
      if (MSB_FIRST) begin
        shift_in_c[i] = {shift_q[i][SPI_SIZE-2:0] & keep_c[SPI_SIZE-2:0], mosi_s[i]};
      end else begin
        shift_in_c[i] = {mosi_s[i], shift_q[i][SPI_SIZE-1:1] & keep_c[SPI_SIZE-2:0]};
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tmo_d      = tmo_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    complete_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (edge_c) begin
          shift_d   = shift_in_c;
          bit_cnt_d = CNT_W'(1);
          tmo_d     = '0;
          state_d   = RECEIVE;
        end
      end
      RECEIVE: begin
        if (edge_c) begin
          shift_d = shift_in_c;
          tmo_d   = '0;
          if (bit_cnt_q == CNT_W'(SPI_SIZE - 1)) begin
            complete_c = 1'b1;
            bit_cnt_d  = '0;
            state_d    = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          // Stalled transfer: drop the partial word, leave the output register alone.
          state_d   = IDLE;
          bit_cnt_d = '0;
          tmo_d     = '0;
          shift_d   = '{default: '0};
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
    // A word finishing while the previous one is consumed in the same cycle is not an overrun.
    if (complete_c) begin
      if (!valid_q || data_ready) begin
        data_d  = shift_in_c;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      shift_q     <= '{default: '0};
      data_q      <= '{default: '0};
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= sclk_s;
      bit_cnt_q   <= bit_cnt_d;
      tmo_q       <= tmo_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign overrun    = overrun_q;
  assign rx_busy    = (state_q == RECEIVE);

endmodule

// File: tb/tb_nspi_rx.sv
// Scoreboard bench for nspi_rx: one MSB-first and one LSB-first instance share the serial bus.
module tb_nspi_rx;

  localparam int CH = 3;
  localparam int SZ = 8;
  localparam int SS = 2;
  localparam int TO = 64;
  localparam int W  = CH * SZ;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          spi_clk = 1'b0;
  logic [CH-1:0] spi_mosi = '0;
  logic          data_ready = 1'b0;

  logic [SZ-1:0] dout_m [CH-1:0];
  logic [SZ-1:0] dout_l [CH-1:0];
  logic          valid_m, valid_l, ovr_m, ovr_l, busy_m, busy_l;
  logic [W-1:0]  flat_m, flat_l;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int valid_rise_cyc = -1;
  bit rand_ready = 1'b0;

  logic [W-1:0] q_m [$];
  logic [W-1:0] q_l [$];

  nspi_rx #(.CHANNEL_NUMBER(CH), .SPI_SIZE(SZ), .MSB_FIRST(1'b1),
            .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut_m (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .data_out(dout_m), .data_valid(valid_m), .data_ready(data_ready),
    .overrun(ovr_m), .rx_busy(busy_m));

  nspi_rx #(.CHANNEL_NUMBER(CH), .SPI_SIZE(SZ), .MSB_FIRST(1'b0),
            .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut_l (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .data_out(dout_l), .data_valid(valid_l), .data_ready(data_ready),
    .overrun(ovr_l), .rx_busy(busy_l));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    flat_m = '0;
    flat_l = '0;
    for (int i = 0; i < CH; i++) begin
      flat_m[i*SZ +: SZ] = dout_m[i];
      flat_l[i*SZ +: SZ] = dout_l[i];
    end
  end

  // Reference for the LSB-first instance: each lane word arrives bit-reversed.
  function automatic logic [W-1:0] rev_lanes(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++)
      for (int b = 0; b < SZ; b++)
        r[i*SZ + (SZ-1-b)] = v[i*SZ + b];
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) data_ready = 1'($urandom_range(0, 1));
  endtask

  // Sends the top nbits of every lane word, MSB of the word first; leaves spi_clk high.
  task automatic send(input logic [W-1:0] vec, input int nbits, input int half, input bit push);
    if (push) begin
      q_m.push_back(vec);
      q_l.push_back(rev_lanes(vec));
    end
    for (int b = SZ-1; b >= SZ-nbits; b--) begin
      spi_clk = 1'b0;
      for (int i = 0; i < CH; i++) spi_mosi[i] = vec[i*SZ + b];
      repeat (half) tick();
      spi_clk = 1'b1;
      last_rise_cyc = cyc;
      repeat (half) tick();
    end
  endtask

  task automatic wait_valid_clear();
    for (int n = 0; n < 300 && valid_m; n++) tick();
    check("wait_valid_clear", W'(valid_m), W'(0));
  endtask

  // Monitor: every accepted word is popped from the scoreboard and compared.
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    logic vprev;
    if (!rst_n) begin
      vprev = 1'b0;
    end else begin
      if (valid_m && !vprev) valid_rise_cyc = cyc;
      vprev = valid_m;
      if (valid_m && data_ready) begin
        if (q_m.size() == 0) begin
          checks++; failures++;
          $display("FAIL word_m unexpected actual=%0h required=none", flat_m);
        end else begin
          e = q_m.pop_front();
          check("word_m", flat_m, e);
        end
      end
      if (valid_l && data_ready) begin
        if (q_l.size() == 0) begin
          checks++; failures++;
          $display("FAIL word_l unexpected actual=%0h required=none", flat_l);
        end else begin
          e = q_l.pop_front();
          check("word_l", flat_l, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fall_cyc;
    logic [W-1:0] v;
    int h;

    // Asynchronous reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", W'(valid_m), W'(0));
    check("rst_busy", W'(busy_m), W'(0));
    check("rst_ovr", W'(ovr_m), W'(0));
    check("rst_data_m", flat_m, W'(0));
    check("rst_data_l", flat_l, W'(0));
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Lanes 0xA5/0x3C/0xFF at the fastest spi_clk, with latency check
    data_ready = 1'b1;
    send({8'hA5, 8'h3C, 8'hFF}, SZ, 1, 1'b1);
    spi_clk = 1'b0;
    repeat (6) tick();
    check("valid_latency", W'(valid_rise_cyc - last_rise_cyc), W'(SS + 1));

    // Lane 0 sends 0x01; LSB-first instance must show 0x80 on lane 0
    send({8'h00, 8'h00, 8'h01}, SZ, 1, 1'b1);
    spi_clk = 1'b0;
    repeat (6) tick();

    // Back-to-back random words, consumer always ready
    for (int k = 0; k < 20; k++) begin
      v = W'($urandom);
      h = $urandom_range(1, 3);
      send(v, SZ, h, 1'b1);
    end
    spi_clk = 1'b0;
    repeat (8) tick();
    check("b2b_ovr_m", W'(ovr_m), W'(0));
    check("b2b_ovr_l", W'(ovr_l), W'(0));

    // Partial word then timeout, then a full word
    send({8'h5A, 8'h5A, 8'h5A} ^ W'($urandom), 5, 1, 1'b0);
    spi_clk = 1'b0;
    fall_cyc = -1;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (!busy_m) begin
        fall_cyc = cyc;
        break;
      end
    end
    check("timeout_fall", W'(fall_cyc - last_rise_cyc), W'(SS + 1 + TO));
    send({8'h5A, 8'h5A, 8'h5A}, SZ, 1, 1'b1);
    spi_clk = 1'b0;
    repeat (6) tick();

    // Random consumer back-pressure, spaced so no word is dropped
    rand_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_valid_clear();
      v = W'($urandom);
      h = $urandom_range(1, 2);
      send(v, SZ, h, 1'b1);
      spi_clk = 1'b0;
    end
    wait_valid_clear();
    rand_ready = 1'b0;
    data_ready = 1'b1;
    repeat (4) tick();
    check("rand_ovr", W'(ovr_m), W'(0));

    // Overrun: consumer stalled while two words arrive
    data_ready = 1'b0;
    send({3{8'h11}}, SZ, 1, 1'b1);
    send({3{8'h22}}, SZ, 1, 1'b0);
    spi_clk = 1'b0;
    repeat (6) tick();
    check("ovr_data_kept", flat_m, W'({3{8'h11}}));
    check("ovr_valid", W'(valid_m), W'(1));
    check("ovr_set_m", W'(ovr_m), W'(1));
    check("ovr_set_l", W'(ovr_l), W'(1));
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("ovr_consumed_valid", W'(valid_m), W'(0));
    repeat (3) tick();
    check("ovr_sticky", W'(ovr_m), W'(1));

    // Reset in the middle of a word, then a clean word 0xC3
    send({3{8'hFF}}, 3, 1, 1'b0);
    spi_clk = 1'b0;
    repeat (4) tick();
    check("busy_before_rst", W'(busy_m), W'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_busy", W'(busy_m), W'(0));
    check("midrst_ovr", W'(ovr_m), W'(0));
    check("midrst_data", flat_m, W'(0));
    tick();
    rst_n = 1'b1;
    data_ready = 1'b1;
    repeat (2) tick();
    send({3{8'hC3}}, SZ, 1, 1'b1);
    spi_clk = 1'b0;
    repeat (6) tick();
    check("rst_word_ovr", W'(ovr_m), W'(0));

    repeat (4) tick();
    check("sb_empty_m", W'(q_m.size()), W'(0));
    check("sb_empty_l", W'(q_l.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
